step_sequencer: RTL and testbench

Parametrised CPU step and memory-phase sequencer for the single-cycle CPU top level. It replaces the fixed divide-by-4 clock scheme with a single fast clock and a phase counter, so the whole design runs on one clock domain. Each CPU step spans RATIO fast cycles. Per step, the block issues a one-cycle CPU step enable, a phase-qualified data-memory write strobe, and a wait-state extension for slow memory or IO. It sits between the board clock/reset and the CPU, IMem, DMem and IOCtrl.

---
 rtl/step_sequencer.sv | 107 ++++++++++
 tb/tb_step_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Single-clock CPU step / memory-phase sequencer: one stepEn pulse every RATIO fast cycles,
// phase-qualified memWE, memWait stretch. Optional RUN/HALT/STEP debug control under STEP_DEBUG_EN.
module step_sequencer #(
  parameter int RATIO    = 4,
  parameter int WE_PHASE = RATIO / 2,
  parameter int WE_PULSE = 0,
  parameter int CNT_W    = 32,
  parameter int PHASE_W  = $clog2(RATIO)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               weReq,
  input  logic               memWait,
`ifdef STEP_DEBUG_EN
  input  logic               dbgHalt,
  input  logic               dbgStep,
  output logic               halted,
`endif
  output logic               stepEn,
  output logic               cpuClk,
  output logic [PHASE_W-1:0] phase,
  output logic               memWE,
  output logic [CNT_W-1:0]   stepCount
);

  localparam logic [PHASE_W-1:0] LAST_PHASE = PHASE_W'(RATIO - 1);
  localparam logic [PHASE_W-1:0] WE_PH      = PHASE_W'(WE_PHASE);
  localparam logic [PHASE_W-1:0] HALF_PHASE = PHASE_W'(RATIO / 2);

  logic               running;
  logic               lastPhase;
  logic               weWindow;
  logic [PHASE_W-1:0] phaseNext;

`ifdef STEP_DEBUG_EN
  typedef enum logic [1:0] {RUN, HALT, STEP} dbgState_t;

  dbgState_t state;
  dbgState_t stateNext;
  logic      dbgStepQ;
  logic      dbgStepRise;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= RUN;
      dbgStepQ <= 1'b0;
    end else begin
      state    <= stateNext;
      dbgStepQ <= dbgStep;
    end
  end

  // Edges seen outside HALT are simply dropped; nothing is queued.
  assign dbgStepRise = dbgStep & ~dbgStepQ;

  always_comb begin
    stateNext = state;
    case (state)
      RUN:     if (stepEn && dbgHalt) stateNext = HALT;
      HALT: begin
        if (dbgStepRise)   stateNext = STEP;
        else if (!dbgHalt) stateNext = RUN;
      end
      STEP:    if (stepEn) stateNext = dbgHalt ? HALT : RUN;
      default: stateNext = RUN;
    endcase
  end

  assign running = (state != HALT);
  assign halted  = (state == HALT);
`else
  assign running = 1'b1;
`endif

  assign lastPhase = (phase == LAST_PHASE);

  // Gated by rst so a step abandoned by reset never produces a stepEn.
  assign stepEn = rst && lastPhase && !memWait && running;

  assign cpuClk = (phase < HALF_PHASE);

  assign weWindow = (WE_PULSE != 0) ? (phase == WE_PH) : (phase >= WE_PH);
  assign memWE    = weReq && running && weWindow;

  // HALT parks the counter at 0 so leaving HALT always starts a fresh step.
  always_comb begin
    phaseNext = phase;
    if (!running) begin
      phaseNext = '0;
    end else if (lastPhase) begin
      if (!memWait) phaseNext = '0;
    end else begin
      phaseNext = phase + PHASE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase     <= '0;
      stepCount <= '0;
    end else begin
      phase <= phaseNext;
      if (stepEn) stepCount <= stepCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Bench for step_sequencer: three configurations driven from shared inputs and checked every
// cycle against a step-position reference model; honours STEP_DEBUG_EN when defined.
module tb_step_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, weReq, memWait, dbgHalt, dbgStep;

  logic [1:0]  ph0, ph1;
  logic [2:0]  ph2;
  logic [3:0]  sc0;
  logic [31:0] sc1, sc2;
  logic        se0, se1, se2, we0, we1, we2, ck0, ck1, ck2, h0, h1, h2;

  step_sequencer #(.RATIO(4), .WE_PHASE(2), .WE_PULSE(0), .CNT_W(4)) u0 (
    .clk(clk), .rst(rst), .weReq(weReq), .memWait(memWait),
`ifdef STEP_DEBUG_EN
    .dbgHalt(dbgHalt), .dbgStep(dbgStep), .halted(h0),
`endif
    .stepEn(se0), .cpuClk(ck0), .phase(ph0), .memWE(we0), .stepCount(sc0));

  step_sequencer #(.RATIO(4), .WE_PHASE(2), .WE_PULSE(1), .CNT_W(32)) u1 (
    .clk(clk), .rst(rst), .weReq(weReq), .memWait(memWait),
`ifdef STEP_DEBUG_EN
    .dbgHalt(dbgHalt), .dbgStep(dbgStep), .halted(h1),
`endif
    .stepEn(se1), .cpuClk(ck1), .phase(ph1), .memWE(we1), .stepCount(sc1));

  step_sequencer #(.RATIO(5), .WE_PHASE(1), .WE_PULSE(0), .CNT_W(32)) u2 (
    .clk(clk), .rst(rst), .weReq(weReq), .memWait(memWait),
`ifdef STEP_DEBUG_EN
    .dbgHalt(dbgHalt), .dbgStep(dbgStep), .halted(h2),
`endif
    .stepEn(se2), .cpuClk(ck2), .phase(ph2), .memWE(we2), .stepCount(sc2));

`ifndef STEP_DEBUG_EN
  assign h0 = 1'b0;
  assign h1 = 1'b0;
  assign h2 = 1'b0;
`endif

  logic [31:0] phO[3], cntO[3];
  logic        seO[3], weO[3], ckO[3], hO[3];
  assign phO[0] = 32'(ph0);  assign phO[1] = 32'(ph1);  assign phO[2] = 32'(ph2);
  assign cntO[0] = 32'(sc0); assign cntO[1] = sc1;      assign cntO[2] = sc2;
  assign seO[0] = se0; assign seO[1] = se1; assign seO[2] = se2;
  assign weO[0] = we0; assign weO[1] = we1; assign weO[2] = we2;
  assign ckO[0] = ck0; assign ckO[1] = ck1; assign ckO[2] = ck2;
  assign hO[0]  = h0;  assign hO[1]  = h1;  assign hO[2]  = h2;

  int total = 0;
  int bad   = 0;

  // Configuration of each instance, as seen by the model.
  int rat[3] = '{4, 4, 5};
  int wph[3] = '{2, 2, 1};
  int pul[3] = '{0, 1, 0};
  int cw[3]  = '{4, 32, 32};

  // Model: cycles elapsed in the current step, completed steps, parked flag.
  int              pos[3];
  longint unsigned cnt[3];
  bit              hm[3];
  bit              prevStep;

  // Outputs captured at the most recent check point.
  bit lastSe[3], lastWe[3];

  task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s dut%0d got=%0h exp=%0h", tag, d, obs, expv);
    end
  endtask

  // One cycle: check outputs mid-cycle, advance the model across the coming edge.
  task automatic cyc();
    bit seE[3];
    bit rise;
    #1;
    for (int d = 0; d < 3; d++) begin
      int ph;
      bit run, win, we, ck;
      ph  = (pos[d] > rat[d] - 1) ? rat[d] - 1 : pos[d];
      run = !hm[d];
      seE[d] = rst && run && (ph == rat[d] - 1) && !memWait;
      win = pul[d] ? (ph == wph[d]) : (ph >= wph[d]);
      we  = weReq && run && win;
      ck  = (ph < rat[d] / 2);
      check("phase", d, phO[d], 32'(ph));
      check("stepEn", d, 32'(seO[d]), 32'(seE[d]));
      check("memWE", d, 32'(weO[d]), 32'(we));
      check("cpuClk", d, 32'(ckO[d]), 32'(ck));
      check("stepCount", d, cntO[d], 32'(cnt[d]));
`ifdef STEP_DEBUG_EN
      check("halted", d, 32'(hO[d]), 32'(hm[d]));
`endif
      lastSe[d] = seO[d];
      lastWe[d] = weO[d];
    end
    rise = dbgStep && !prevStep;
    for (int d = 0; d < 3; d++) begin
      longint unsigned mask;
      mask = (cw[d] >= 32) ? 64'hFFFF_FFFF : ((64'd1 << cw[d]) - 64'd1);
      if (!rst) begin
        pos[d] = 0; cnt[d] = 0; hm[d] = 1'b0;
      end else if (hm[d]) begin
        pos[d] = 0;
        if (rise || !dbgHalt) hm[d] = 1'b0;
      end else if (seE[d]) begin
        pos[d] = 0;
        cnt[d] = (cnt[d] + 1) & mask;
        if (dbgHalt) hm[d] = 1'b1;
      end else begin
        pos[d] = pos[d] + 1;
      end
    end
    prevStep = rst ? dbgStep : 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int n, nSe, nWe, waits;
    logic [31:0] c0;
    rst = 1'b0; weReq = 1'b1; memWait = 1'b0; dbgHalt = 1'b0; dbgStep = 1'b0;
    for (int d = 0; d < 3; d++) begin pos[d] = 0; cnt[d] = 0; hm[d] = 1'b0; end
    prevStep = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset values with weReq held high.
    cyc();
    check("rst_phase", 0, phO[0], 32'd0);
    check("rst_cpuClk", 0, 32'(ckO[0]), 32'd1);

    // Free run, 40 cycles.
    rst = 1'b1; weReq = 1'b0;
    nSe = 0;
    for (int i = 0; i < 40; i++) begin cyc(); if (lastSe[0]) nSe++; end
    check("run40_pulses", 0, 32'(nSe), 32'd10);
    check("run40_count", 0, cntO[0], 32'd10);
    check("run40_count", 2, cntO[2], 32'd8);

    // Write windows: held vs pulsed strobe.
    weReq = 1'b1;
    nWe = 0; n = 0;
    for (int i = 0; i < 8; i++) begin cyc(); if (lastWe[0]) nWe++; if (lastWe[1]) n++; end
    check("we_held_cycles", 0, 32'(nWe), 32'd4);
    check("we_pulse_cycles", 1, 32'(n), 32'd2);

    // Three wait cycles in the last phase: 7-cycle step, one stepEn, memWE for 5 cycles.
    waits = 3; nSe = 0; nWe = 0;
    for (int i = 0; i < 7; i++) begin
      memWait = (pos[0] >= 3) && (waits > 0);
      cyc();
      if (memWait) waits--;
      if (lastSe[0]) nSe++;
      if (lastWe[0]) nWe++;
      if (i == 6) check("wait_last_cycle_stepEn", 0, 32'(lastSe[0]), 32'd1);
    end
    memWait = 1'b0;
    check("wait_pulses", 0, 32'(nSe), 32'd1);
    check("wait_we_cycles", 0, 32'(nWe), 32'd5);

    // Counter wrap on the 4-bit instance.
    rst = 1'b0; cyc(); rst = 1'b1; weReq = 1'b0;
    for (int i = 0; i < 64; i++) cyc();
    check("wrap16", 0, cntO[0], 32'd0);
    check("wrap16", 1, cntO[1], 32'd16);
    for (int i = 0; i < 4; i++) cyc();
    check("wrap17", 0, cntO[0], 32'd1);
    check("wrap17", 1, cntO[1], 32'd17);

    // Random traffic including waits and occasional mid-step reset.
    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 49) != 0);
      weReq   = $urandom_range(0, 1) != 0;
      memWait = ($urandom_range(0, 3) == 0);
      cyc();
    end

`ifdef STEP_DEBUG_EN
    rst = 1'b0; weReq = 1'b0; memWait = 1'b0; cyc(); rst = 1'b1;
    // Halt raised mid-step: the step finishes, then the block parks at phase 0.
    cyc(); cyc();
    dbgHalt = 1'b1;
    cyc(); cyc();
    check("halt_entered", 0, 32'(hO[0]), 32'd1);
    check("halt_phase", 0, phO[0], 32'd0);
    c0 = cntO[0];
    for (int i = 0; i < 3; i++) cyc();
    dbgStep = 1'b1; cyc(); dbgStep = 1'b0;
    nSe = 0;
    for (int i = 0; i < 8; i++) begin cyc(); if (lastSe[0]) nSe++; end
    check("single_step_pulses", 0, 32'(nSe), 32'd1);
    check("single_step_count", 0, cntO[0], (c0 + 32'd1) & 32'hF);
    check("single_step_rehalt", 0, 32'(hO[0]), 32'd1);
    dbgHalt = 1'b0;
    nSe = 0;
    for (int i = 0; i < 13; i++) begin cyc(); if (lastSe[0]) nSe++; end
    check("resume_pulses", 0, 32'(nSe), 32'd3);
    check("resume_running", 0, 32'(hO[0]), 32'd0);

    for (int i = 0; i < 400; i++) begin
      rst     = ($urandom_range(0, 99) != 0);
      weReq   = $urandom_range(0, 1) != 0;
      memWait = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 7) == 0) dbgHalt = !dbgHalt;
      dbgStep = ($urandom_range(0, 5) == 0);
      cyc();
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
